// File: rtl/pwm_pkg.sv
// Shared PWM definitions: fade FSM states, default duty width and the SPI
// register map used by both the SPI peripheral and the fade controller.
package pwm_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        IDLE     = 2'd1,
        UP       = 2'd2,
        DOWN     = 2'd3
    } fade_state_t;

    localparam int DEFAULT_DUTY_W = 8;

    localparam logic [7:0] ADDR_CTRL           = 8'h00;
    localparam logic [7:0] ADDR_DUTY_CYCLE     = 8'h01;
    localparam logic [7:0] ADDR_STEP_PERIOD_LO = 8'h02;
    localparam logic [7:0] ADDR_STEP_PERIOD_HI = 8'h03;
    localparam logic [7:0] ADDR_STEP_SIZE      = 8'h04;

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: counts 0..max(period,1)-1 and emits a one-cycle tick
// on wrap; held at zero while clear is high.
module step_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [PRESC_W-1:0] period,
    output logic               tick
);

    logic [PRESC_W-1:0] r_cnt;
    logic [PRESC_W-1:0] w_last;

    always_comb begin
        w_last = (period == '0) ? '0 : period - PRESC_W'(1);
    end

    // >= rather than == so a period shrunk mid-count still wraps promptly
    assign tick = !clear && (r_cnt >= w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/pwm_fade_controller.sv
// Fade engine driving the PWM generator duty input: approaches SPI-written
// targets in saturating steps of step_size every step_period clocks.
module pwm_fade_controller
    import pwm_pkg::*;
#(
    parameter int DUTY_W  = DEFAULT_DUTY_W,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [DUTY_W-1:0]  target_duty,
    input  logic               target_valid,
    input  logic [PRESC_W-1:0] step_period,
    input  logic [3:0]         step_size,
    output logic [DUTY_W-1:0]  duty_out,
    output logic               busy,
    output logic               done
);

    fade_state_t       r_state;
    logic [DUTY_W-1:0] r_tgt;
    logic [DUTY_W-1:0] r_cur;
    logic              r_done;

    logic [DUTY_W-1:0] w_teff;
    logic [DUTY_W-1:0] w_next;
    logic [DUTY_W:0]   w_step;
    logic [DUTY_W:0]   w_sum;
    logic [DUTY_W:0]   w_diff;
    logic [DUTY_W:0]   w_teff_x;
    logic              w_busy;
    logic              w_tick;
    logic              w_up;

    assign w_busy   = (r_state == UP) || (r_state == DOWN);
    assign duty_out = r_cur;
    assign busy     = w_busy;
    assign done     = r_done;

    // Prescaler only runs while ramping, so every fresh ramp starts a full period
    step_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_step_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!w_busy),
        .period (step_period),
        .tick   (w_tick)
    );

    // Direction and saturated next value both follow the effective target,
    // so a same-cycle retarget steers the step immediately.
    always_comb begin
        w_teff   = target_valid ? target_duty : r_tgt;
        w_up     = w_teff > r_cur;
        w_step   = (step_size == 4'd0) ? (DUTY_W+1)'(1) : (DUTY_W+1)'(step_size);
        w_teff_x = {1'b0, w_teff};
        w_sum    = {1'b0, r_cur} + w_step;
        w_diff   = {1'b0, r_cur} - w_step;
        w_next   = r_cur;
        if (w_up) begin
            w_next = (w_sum >= w_teff_x) ? w_teff : w_sum[DUTY_W-1:0];
        end else if (w_teff < r_cur) begin
            w_next = (w_diff[DUTY_W] || (w_diff <= w_teff_x)) ? w_teff : w_diff[DUTY_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DISABLED;
            r_tgt   <= '0;
            r_cur   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (target_valid) begin
                r_tgt <= target_duty;
            end
            if (!enable) begin
                r_state <= DISABLED;
                r_cur   <= '0;
            end else begin
                case (r_state)
                    DISABLED: begin
                        r_cur   <= '0;
                        r_state <= (w_teff != '0) ? UP : IDLE;
                    end
                    IDLE: begin
                        if (w_up) begin
                            r_state <= UP;
                        end else if (w_teff < r_cur) begin
                            r_state <= DOWN;
                        end
                    end
                    UP, DOWN: begin
                        if (w_teff == r_cur) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else if (w_tick && (w_next == w_teff)) begin
                            r_cur   <= w_next;
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            if (w_tick) begin
                                r_cur <= w_next;
                            end
                            r_state <= w_up ? UP : DOWN;
                        end
                    end
                    default: begin
                        r_state <= DISABLED;
                        r_cur   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Directed self-checking bench for pwm_fade_controller: ramps, saturation,
// retargeting, enable drop and asynchronous reset.
module tb_pwm_fade_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  target_duty;
    logic        target_valid;
    logic [15:0] step_period;
    logic [3:0]  step_size;
    logic [7:0]  duty_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_fade_controller #(
        .DUTY_W  (8),
        .PRESC_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .target_duty  (target_duty),
        .target_valid (target_valid),
        .step_period  (step_period),
        .step_size    (step_size),
        .duty_out     (duty_out),
        .busy         (busy),
        .done         (done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic tv, input logic [7:0] td,
                                 input logic [15:0] per, input logic [3:0] sz);
        enable       = en;
        target_valid = tv;
        target_duty  = td;
        step_period  = per;
        step_size    = sz;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int doneCnt;

        // Reset state
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 16'd10, 4'd4);
        #12;
        checkOutput("reset_duty", 32'(duty_out), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        nextEdge();
        applyStimulus(1'b1, 1'b0, 8'h00, 16'd10, 4'd4);
        nextEdge();
        checkOutput("idle_duty", 32'(duty_out), 32'h0);
        checkOutput("idle_busy", 32'(busy), 32'h0);

        // Ramp 0x00 -> 0x40, step 4 every 10 clocks
        $display("[TB] ramp up to 0x40");
        applyStimulus(1'b1, 1'b1, 8'h40, 16'd10, 4'd4);
        nextEdge();
        applyStimulus(1'b1, 1'b0, 8'h40, 16'd10, 4'd4);
        checkOutput("t1_busy_start", 32'(busy), 32'h1);
        checkOutput("t1_duty_start", 32'(duty_out), 32'h0);
        for (int c = 1; c <= 160; c++) begin
            nextEdge();
            checkOutput("t1_duty", 32'(duty_out), 32'(4 * (c / 10)));
            checkOutput("t1_done", 32'(done), 32'(c == 160));
            checkOutput("t1_busy", 32'(busy), 32'(c < 160));
        end
        nextEdge();
        checkOutput("t1_done_after", 32'(done), 32'h0);
        checkOutput("t1_duty_after", 32'(duty_out), 32'h40);

        // Down 0x40 -> 0x3E with oversize step
        $display("[TB] saturating step down to 0x3E");
        applyStimulus(1'b1, 1'b1, 8'h3E, 16'd1, 4'd15);
        nextEdge();
        applyStimulus(1'b1, 1'b0, 8'h3E, 16'd1, 4'd15);
        checkOutput("t2_busy", 32'(busy), 32'h1);
        checkOutput("t2_duty_hold", 32'(duty_out), 32'h40);
        nextEdge();
        checkOutput("t2_duty", 32'(duty_out), 32'h3E);
        checkOutput("t2_done", 32'(done), 32'h1);
        checkOutput("t2_busy_end", 32'(busy), 32'h0);
        nextEdge();
        checkOutput("t2_duty_after", 32'(duty_out), 32'h3E);
        checkOutput("t2_done_after", 32'(done), 32'h0);

        // Up to 0xF8 then saturate at 0xFF, then step_size 0 acts as 1
        $display("[TB] saturation at 0xFF");
        applyStimulus(1'b1, 1'b1, 8'hF8, 16'd1, 4'd15);
        nextEdge();
        applyStimulus(1'b1, 1'b0, 8'hF8, 16'd1, 4'd15);
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            nextEdge();
            n++;
        end
        checkOutput("t3_f8_done", 32'(done), 32'h1);
        checkOutput("t3_f8_steps", 32'(n), 32'd13);
        checkOutput("t3_f8_duty", 32'(duty_out), 32'hF8);
        applyStimulus(1'b1, 1'b1, 8'hFF, 16'd1, 4'd15);
        nextEdge();
        applyStimulus(1'b1, 1'b0, 8'hFF, 16'd1, 4'd15);
        nextEdge();
        checkOutput("t3_ff_duty", 32'(duty_out), 32'hFF);
        checkOutput("t3_ff_done", 32'(done), 32'h1);
        applyStimulus(1'b1, 1'b1, 8'hFC, 16'd1, 4'd0);
        nextEdge();
        applyStimulus(1'b1, 1'b0, 8'hFC, 16'd1, 4'd0);
        for (int k = 1; k <= 3; k++) begin
            nextEdge();
            checkOutput("t3_size0_duty", 32'(duty_out), 32'(255 - k));
            checkOutput("t3_size0_done", 32'(done), 32'(k == 3));
        end

        // Mid-ramp retarget 0x80 -> 0x10 at duty 0x20
        $display("[TB] mid-ramp retarget");
        applyStimulus(1'b0, 1'b0, 8'hFC, 16'd2, 4'd1);
        nextEdge();
        checkOutput("t4_off_duty", 32'(duty_out), 32'h0);
        checkOutput("t4_off_busy", 32'(busy), 32'h0);
        applyStimulus(1'b1, 1'b1, 8'h80, 16'd2, 4'd1);
        nextEdge();
        applyStimulus(1'b1, 1'b0, 8'h80, 16'd2, 4'd1);
        for (int c = 1; c <= 64; c++) begin
            nextEdge();
            checkOutput("t4_up_duty", 32'(duty_out), 32'(c / 2));
        end
        applyStimulus(1'b1, 1'b1, 8'h10, 16'd2, 4'd1);
        nextEdge();
        applyStimulus(1'b1, 1'b0, 8'h10, 16'd2, 4'd1);
        checkOutput("t4_rt_duty", 32'(duty_out), 32'h20);
        checkOutput("t4_rt_busy", 32'(busy), 32'h1);
        doneCnt = 0;
        for (int c = 1; c <= 40; c++) begin
            nextEdge();
            if (done === 1'b1) doneCnt++;
            if (c <= 31) begin
                checkOutput("t4_dn_duty", 32'(duty_out), 32'(32 - (c + 1) / 2));
            end
            checkOutput("t4_dn_done", 32'(done), 32'(c == 31));
        end
        checkOutput("t4_done_count", 32'(doneCnt), 32'd1);
        checkOutput("t4_final_duty", 32'(duty_out), 32'h10);

        // Enable drop at 0x30 mid-ramp, then re-enable toward retained 0x50
        $display("[TB] enable drop");
        applyStimulus(1'b1, 1'b1, 8'h50, 16'd1, 4'd1);
        nextEdge();
        applyStimulus(1'b1, 1'b0, 8'h50, 16'd1, 4'd1);
        for (int k = 1; k <= 32; k++) begin
            nextEdge();
            checkOutput("t5_up_duty", 32'(duty_out), 32'(16 + k));
        end
        applyStimulus(1'b0, 1'b0, 8'h50, 16'd1, 4'd1);
        nextEdge();
        checkOutput("t5_drop_duty", 32'(duty_out), 32'h0);
        checkOutput("t5_drop_busy", 32'(busy), 32'h0);
        checkOutput("t5_drop_done", 32'(done), 32'h0);
        nextEdge();
        checkOutput("t5_off_duty", 32'(duty_out), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h50, 16'd1, 4'd1);
        nextEdge();
        checkOutput("t5_re_busy", 32'(busy), 32'h1);
        checkOutput("t5_re_duty", 32'(duty_out), 32'h0);
        for (int k = 1; k <= 80; k++) begin
            nextEdge();
            checkOutput("t5_re_ramp", 32'(duty_out), 32'(k));
            checkOutput("t5_re_done", 32'(done), 32'(k == 80));
        end

        // Asynchronous reset mid-ramp
        $display("[TB] async reset");
        applyStimulus(1'b1, 1'b1, 8'h20, 16'd1, 4'd1);
        nextEdge();
        applyStimulus(1'b1, 1'b0, 8'h20, 16'd1, 4'd1);
        nextEdge();
        nextEdge();
        nextEdge();
        checkOutput("t6_pre_duty", 32'(duty_out), 32'h4D);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_duty", 32'(duty_out), 32'h0);
        checkOutput("t6_rst_busy", 32'(busy), 32'h0);
        checkOutput("t6_rst_done", 32'(done), 32'h0);
        #2;
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            nextEdge();
            checkOutput("t6_post_duty", 32'(duty_out), 32'h0);
            checkOutput("t6_post_busy", 32'(busy), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
